alu_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared 32-bit single-cycle ALU (ADD/SUB/AND/OR, NZCV flags). It accepts operation requests from two clients over valid/ready handshakes and grants the ALU round-robin. It drives the ALU from registered operands and returns the registered result and flags to the granted client over a valid/ready response channel. It sits between the execute-stage clients (e.g. main datapath and address/auxiliary unit) and the single ALU instance.

---
 rtl/alu_arb.sv | 150 +++++++++++++++
 tb/tb_alu_arb.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arb.sv
// Two-requester arbiter/sequencer in front of the shared 32-bit ADD/SUB/AND/OR ALU.
// Latency: request handshake on edge N, ALU evaluates in cycle N+1, response valid from cycle N+2.
// Backpressure: one op in flight; req_ready stays low until the granted client accepts its response.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   req_valid/req_ready [1:0]      per-requester request handshake
//   req_a0/req_b0/req_ctrl0        requester 0 operands and ALUControl
//   req_a1/req_b1/req_ctrl1        requester 1 operands and ALUControl
//   rsp_valid/rsp_ready [1:0]      per-requester response handshake
//   rsp_result, rsp_flags          registered result and {N,Z,C,V}, shared by both channels
//   alu_a, alu_b, alu_ctrl         registered operands to the ALU
//   alu_result, alu_flags          ALU outputs, captured during EXEC
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties);
// the default build arbitrates ties round-robin.

module alu_arb #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [1:0]       req_ctrl0,
    input  logic [1:0]       req_ctrl1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       r_state;
    logic             r_grant;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_ctrl;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    logic             w_tie_grant;
    logic             w_grant;
    logic             w_req_hs;
    logic             w_rsp_hs;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_tie_grant = 1'b0;
`else
    // Round-robin pointer: the requester granted most recently. Reset to 1 so
    // requester 0 wins the first tie after reset.
    logic r_last;
    assign w_tie_grant = ~r_last;
`endif

    always_comb begin
        w_grant = 1'b0;
        case (req_valid)
            2'b01:   w_grant = 1'b0;
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = w_tie_grant;
            default: w_grant = 1'b0;
        endcase
    end

    // In IDLE the grant is decided and accepted in the same cycle, so any
    // valid request handshakes immediately.
    assign w_req_hs  = (r_state == S_IDLE) && (req_valid != 2'b00);
    assign w_rsp_hs  = (r_state == S_RESP) && rsp_ready[r_grant];

    assign req_ready = w_req_hs ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid = (r_state == S_RESP) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;

    assign rsp_result = r_result;
    assign rsp_flags  = r_flags;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_ctrl   = r_ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_hs) begin
                        r_state <= S_EXEC;
                        r_grant <= w_grant;
                    end
                end
                S_EXEC: r_state <= S_RESP;
                S_RESP: begin
                    if (w_rsp_hs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (w_req_hs) begin
            r_last <= w_grant;
        end
    end
`endif

    // Operand registers feed the ALU directly; they only change on a request
    // handshake so the ALU never sees the raw request inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_ctrl <= 2'b00;
        end else if (w_req_hs) begin
            r_a    <= w_grant ? req_a1    : req_a0;
            r_b    <= w_grant ? req_b1    : req_b0;
            r_ctrl <= w_grant ? req_ctrl1 : req_ctrl0;
        end
    end

    // Response registers are loaded only at the end of EXEC and stay stable
    // for the whole RESP phase regardless of how long the client stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_flags  <= 4'b0000;
        end else if (r_state == S_EXEC) begin
            r_result <= alu_result;
            r_flags  <= alu_flags;
        end
    end

endmodule

// File: tb/tb_alu_arb.sv
module tb_alu_arb;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  ctrl;
        bit          has_exp;
        logic [31:0] exp_res;
        logic [3:0]  exp_flags;
    } op_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_ctrl0, req_ctrl1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [31:0] alu_a, alu_b;
    logic [1:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;

    int n_cmp = 0;
    int n_bad = 0;
    int m_last = 1;
    op_t q0[$];
    op_t q1[$];
    int grant_log[$];

    always #5 clk = ~clk;

    alu_arb #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_ctrl0(req_ctrl0), .req_ctrl1(req_ctrl1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags)
    );

    // Behavioural ALU: returns {N,Z,C,V, result}.
    function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] ctrl);
        logic [32:0] sum;
        logic [31:0] res;
        logic        c, v;
        sum = ctrl[0] ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
        case (ctrl)
            2'b10:   res = a & b;
            2'b11:   res = a | b;
            default: res = sum[31:0];
        endcase
        c = ~ctrl[1] & sum[32];
        v = ~ctrl[1] & (a[31] ^ res[31]) & ~(ctrl[0] ^ a[31] ^ b[31]);
        return {res[31], (res == 32'd0), c, v, res};
    endfunction

    always_comb begin
        {alu_flags, alu_result} = alu_ref(alu_a, alu_b, alu_ctrl);
    end

    function automatic int pick(input logic [1:0] v, input int last);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        return 0;
`else
        return 1 - last;
`endif
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic op_t mk_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c,
                                  input bit he, input logic [31:0] er, input logic [3:0] ef);
        op_t o;
        o.a = a; o.b = b; o.ctrl = c; o.has_exp = he; o.exp_res = er; o.exp_flags = ef;
        return o;
    endfunction

    function automatic op_t rnd_op();
        return mk_op(rnd_word(), rnd_word(), 2'($urandom_range(0, 3)), 1'b0, 32'd0, 4'd0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle-level scoreboard: one op in flight, grant per tie rule, response two cycles
    // after the request handshake, held until the granted client accepts it.
    task automatic run_traffic(input bit rnd, input int hold, input int budget);
        int          phase = 0;
        int          g = 0;
        int          wait_c = 0;
        int          cyc = 0;
        op_t         cur;
        logic [35:0] r;
        logic [1:0]  oh;
        cur = mk_op(32'd0, 32'd0, 2'b00, 1'b0, 32'd0, 4'd0);
        while ((q0.size() > 0 || q1.size() > 0 || phase != 0) && cyc < budget) begin
            req_valid[0] = (q0.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
            req_valid[1] = (q1.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
            if (q0.size() > 0) begin
                req_a0 = q0[0].a; req_b0 = q0[0].b; req_ctrl0 = q0[0].ctrl;
            end else begin
                req_a0 = $urandom; req_b0 = $urandom; req_ctrl0 = 2'($urandom_range(0, 3));
            end
            if (q1.size() > 0) begin
                req_a1 = q1[0].a; req_b1 = q1[0].b; req_ctrl1 = q1[0].ctrl;
            end else begin
                req_a1 = $urandom; req_b1 = $urandom; req_ctrl1 = 2'($urandom_range(0, 3));
            end
            oh = (g == 1) ? 2'b10 : 2'b01;
            if (rnd)
                rsp_ready = 2'($urandom_range(0, 3));
            else if (phase == 2 && wait_c < hold)
                rsp_ready = ~oh;
            else
                rsp_ready = 2'b11;
            #1;
            case (phase)
                0: begin
                    logic [1:0] exp_rdy;
                    exp_rdy = 2'b00;
                    if (req_valid != 2'b00) begin
                        g = pick(req_valid, m_last);
                        exp_rdy = (g == 1) ? 2'b10 : 2'b01;
                    end
                    n_cmp++;
                    if ({req_ready, rsp_valid} !== {exp_rdy, 2'b00}) begin
                        n_bad++;
                        $display("FAIL idle_handshake cyc=%0d got rdy=%b rsp_v=%b want rdy=%b rsp_v=00",
                                 cyc, req_ready, rsp_valid, exp_rdy);
                    end
                    if (req_valid != 2'b00) begin
                        cur = (g == 1) ? q1.pop_front() : q0.pop_front();
                        m_last = g;
                        grant_log.push_back(g);
                        phase = 1;
                    end
                end
                1: begin
                    n_cmp++;
                    if ({req_ready, rsp_valid, alu_a, alu_b, alu_ctrl} !==
                        {4'b0000, cur.a, cur.b, cur.ctrl}) begin
                        n_bad++;
                        $display("FAIL exec_phase cyc=%0d got rdy=%b rsp_v=%b a=%h b=%h c=%b want rdy=00 rsp_v=00 a=%h b=%h c=%b",
                                 cyc, req_ready, rsp_valid, alu_a, alu_b, alu_ctrl, cur.a, cur.b, cur.ctrl);
                    end
                    phase = 2;
                    wait_c = 0;
                end
                default: begin
                    r = alu_ref(cur.a, cur.b, cur.ctrl);
                    n_cmp++;
                    if ({req_ready, rsp_valid, rsp_flags, rsp_result} !== {2'b00, oh, r}) begin
                        n_bad++;
                        $display("FAIL resp_phase cyc=%0d got rdy=%b rsp_v=%b flags=%b res=%h want rdy=00 rsp_v=%b flags=%b res=%h",
                                 cyc, req_ready, rsp_valid, rsp_flags, rsp_result, oh, r[35:32], r[31:0]);
                    end
                    if (cur.has_exp) begin
                        n_cmp++;
                        if ({rsp_flags, rsp_result} !== {cur.exp_flags, cur.exp_res}) begin
                            n_bad++;
                            $display("FAIL directed_value got flags=%b res=%h want flags=%b res=%h",
                                     rsp_flags, rsp_result, cur.exp_flags, cur.exp_res);
                        end
                    end
                    if (rsp_ready[g]) phase = 0;
                    else wait_c++;
                end
            endcase
            tick();
            cyc++;
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        if (cyc >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL traffic_timeout cyc=%0d pending q0=%0d q1=%0d phase=%0d want all drained",
                     cyc, q0.size(), q1.size(), phase);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();
        tick();
        reset = 1'b0;
        m_last = 1;
    endtask

    task automatic test_reset();
        req_a0 = 32'd0; req_b0 = 32'd0; req_a1 = 32'd0; req_b1 = 32'd0;
        req_ctrl0 = 2'b00; req_ctrl1 = 2'b00;
        apply_reset();
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_result, rsp_flags, alu_a, alu_b, alu_ctrl} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got rdy=%b rsp_v=%b res=%h flags=%b a=%h b=%h c=%b want all zero",
                     req_ready, rsp_valid, rsp_result, rsp_flags, alu_a, alu_b, alu_ctrl);
        end
        req_valid = 2'b11;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL first_tie got rdy=%b want 01", req_ready);
        end
        req_valid = 2'b00;
        #1;
        n_cmp++;
        if (req_ready !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_no_valid got rdy=%b want 00", req_ready);
        end
    endtask

    task automatic test_directed();
        q0.push_back(mk_op(32'd5, 32'd3, 2'b00, 1'b1, 32'h0000_0008, 4'b0000));
        run_traffic(1'b0, 0, 50);
        q1.push_back(mk_op(32'd3, 32'd5, 2'b01, 1'b1, 32'hFFFF_FFFE, 4'b1000));
        q1.push_back(mk_op(32'd5, 32'd5, 2'b01, 1'b1, 32'h0000_0000, 4'b0110));
        run_traffic(1'b0, 0, 50);
        q0.push_back(mk_op(32'h7FFF_FFFF, 32'd1, 2'b00, 1'b1, 32'h8000_0000, 4'b1001));
        q0.push_back(mk_op(32'h0000_00F0, 32'h0000_000F, 2'b11, 1'b1, 32'h0000_00FF, 4'b0000));
        q0.push_back(mk_op(32'hF0F0_1234, 32'h0FF0_FFFF, 2'b10, 1'b1, 32'h00F0_1234, 4'b0000));
        run_traffic(1'b0, 0, 50);
    endtask

    task automatic test_round_robin();
        int exp_g;
        apply_reset();
        grant_log.delete();
        for (int i = 0; i < 6; i++) begin
            q0.push_back(rnd_op());
            q1.push_back(rnd_op());
        end
        run_traffic(1'b0, 0, 200);
        n_cmp++;
        if (grant_log.size() != 12) begin
            n_bad++;
            $display("FAIL rr_count got %0d want 12", grant_log.size());
        end
        for (int i = 0; i < grant_log.size() && i < 12; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = (i < 6) ? 0 : 1;
`else
            exp_g = i % 2;
`endif
            n_cmp++;
            if (grant_log[i] != exp_g) begin
                n_bad++;
                $display("FAIL rr_order idx=%0d got %0d want %0d", i, grant_log[i], exp_g);
            end
        end
    endtask

    task automatic test_backpressure();
        q0.push_back(mk_op(32'd100, 32'd1, 2'b01, 1'b1, 32'd99, 4'b0010));
        run_traffic(1'b0, 4, 50);
        q1.push_back(rnd_op());
        run_traffic(1'b0, 4, 50);
    endtask

    task automatic test_reset_exec();
        req_a0 = 32'd7; req_b0 = 32'd9; req_ctrl0 = 2'b00;
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        tick();
        req_valid = 2'b00;
        n_cmp++;
        if ({alu_a, alu_b} !== {32'd7, 32'd9}) begin
            n_bad++;
            $display("FAIL exec_before_reset got a=%h b=%h want a=7 b=9", alu_a, alu_b);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_last = 1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_result, rsp_flags, alu_a, alu_b, alu_ctrl} !== '0) begin
            n_bad++;
            $display("FAIL reset_in_exec got rdy=%b rsp_v=%b res=%h flags=%b a=%h b=%h want all zero",
                     req_ready, rsp_valid, rsp_result, rsp_flags, alu_a, alu_b);
        end
        rsp_ready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (rsp_valid !== 2'b00) begin
                n_bad++;
                $display("FAIL discarded_op cyc=%0d got rsp_v=%b want 00", i, rsp_valid);
            end
        end
        rsp_ready = 2'b00;
        q1.push_back(mk_op(32'd2, 32'd2, 2'b00, 1'b1, 32'd4, 4'b0000));
        run_traffic(1'b0, 0, 50);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) q0.push_back(rnd_op());
            else                           q1.push_back(rnd_op());
        end
        run_traffic(1'b1, 0, 3000);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        test_reset();
        test_directed();
        test_round_robin();
        test_backpressure();
        test_reset_exec();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
